// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one completed functional-unit result per
// cycle with a rotating priority pointer and broadcasts it one cycle later.
module cdb_arbiter #(
  parameter int N_FU     = 5,
  parameter int DATA_W   = 32,
  parameter int ROB_IX_W = 3
) (
  input  logic                               clk_in,
  input  logic                               rst_n_in,
  input  logic                               flush_in,
  input  logic [N_FU-1:0]                    fu_valid_in,
  input  logic [N_FU-1:0][DATA_W-1:0]        fu_data_in,
  input  logic [N_FU-1:0][ROB_IX_W-1:0]      fu_rob_ix_in,
  output logic [N_FU-1:0]                    fu_read_out,
  output logic                               cdb_valid_out,
  output logic [DATA_W-1:0]                  cdb_value_out,
  output logic [ROB_IX_W-1:0]                cdb_rob_ix_out,
  output logic [2:0]                         cdb_src_out
);

  localparam int PTR_W = (N_FU > 1) ? $clog2(N_FU) : 1;
  localparam int CW    = PTR_W + 1;

  logic [PTR_W-1:0] r_rr_ptr;
  logic [CW-1:0]    w_cand;
  logic [PTR_W-1:0] w_cand_ix;
  logic [PTR_W-1:0] w_gnt_ix;
  logic             w_gnt_found;
  logic             w_arb_en;
  logic             w_grant_any;
  logic [PTR_W-1:0] w_next_ptr;
  logic [N_FU-1:0]  w_grant;

  // Reset and flush both suppress the pop strobe in the same cycle.
  assign w_arb_en    = rst_n_in & ~flush_in;
  assign w_grant_any = w_arb_en & w_gnt_found;

  // Search from the pointer upward, wrapping, and keep the first requester.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_ix    = '0;
    w_cand      = '0;
    w_cand_ix   = '0;
    for (int k = 0; k < N_FU; k++) begin
      w_cand = {1'b0, r_rr_ptr} + CW'(k);
      if (w_cand >= CW'(N_FU)) begin
        w_cand = w_cand - CW'(N_FU);
      end
      w_cand_ix = w_cand[PTR_W-1:0];
      if (!w_gnt_found && fu_valid_in[w_cand_ix]) begin
        w_gnt_found = 1'b1;
        w_gnt_ix    = w_cand_ix;
      end
    end
  end

  // One-hot pop strobe back to the granted FU.
  always_comb begin
    w_grant = '0;
    if (w_grant_any) begin
      w_grant[w_gnt_ix] = 1'b1;
    end
  end

  assign fu_read_out = w_grant;
  assign w_next_ptr  = (w_gnt_ix == PTR_W'(N_FU - 1)) ? '0 : w_gnt_ix + 1'b1;

  // Register the granted result onto the bus and advance the pointer.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_rr_ptr       <= '0;
      cdb_valid_out  <= 1'b0;
      cdb_value_out  <= '0;
      cdb_rob_ix_out <= '0;
      cdb_src_out    <= '0;
    end else if (flush_in) begin
      // Payload holds; only the strobe and the pointer are cleared.
      r_rr_ptr      <= '0;
      cdb_valid_out <= 1'b0;
    end else if (w_grant_any) begin
      r_rr_ptr       <= w_next_ptr;
      cdb_valid_out  <= 1'b1;
      cdb_value_out  <= fu_data_in[w_gnt_ix];
      cdb_rob_ix_out <= fu_rob_ix_in[w_gnt_ix];
      cdb_src_out    <= 3'(w_gnt_ix);
    end else begin
      cdb_valid_out <= 1'b0;
    end
  end

endmodule
